game_tick_scheduler: RTL and testbench

//  Shares one 100 MHz-derived prescaler among NCH game-timing consumers (player move, enemy move,

---
 rtl/game_tick_scheduler_pkg.sv | 29 ++
 rtl/tick_prescaler.sv | 37 +++
 rtl/game_tick_scheduler.sv | 139 +++++++++++++
 tb/tb_game_tick_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_tick_scheduler_pkg.sv
// Shared definitions for the game tick scheduler: channel indices, config FSM
// states and a constant-evaluable ceil(log2) helper for sizing counters/ports.
package game_tick_scheduler_pkg;

  // Conventional channel assignment used by the game FSMs.
  localparam int unsigned CH_PLAYER = 0;
  localparam int unsigned CH_ENEMY  = 1;
  localparam int unsigned CH_ANIM   = 2;
  localparam int unsigned CH_TIMER  = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } cfg_state_e;

  // ceil(log2(value)); 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r++;
    return r;
  endfunction

  // ceil(log2(value)) but never below 1, for signal widths.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider from clk down to the base tick rate.
// Ports: clk, rst_n (sync, active low), hold (freezes the count),
//        strobe (combinational, high on the last count of each base period
//        while not held).
module tick_prescaler
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BASE_FREQ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic strobe
);

  localparam int unsigned DIV = CLK_FREQ / BASE_FREQ;
  localparam int unsigned PCW = clog2_min1(DIV);

  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           at_end;

  assign at_end = (pcnt_q == PCW'(DIV - 1));
  assign strobe = at_end && !hold;

  // Count 0..DIV-1, frozen while held.
  always_comb begin
    pcnt_d = pcnt_q;
    if (!hold) pcnt_d = at_end ? '0 : pcnt_q + PCW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Per-channel programmable tick generator sharing one base-rate prescaler.
// Ports: clk, rst_n (sync, active low), pause (freezes everything),
//        cfg_valid/cfg_ready handshake with cfg_ch/cfg_en/cfg_period,
//        base_tick (one-cycle pulse per base period), tick[NCH] channel pulses.
// Config writes are latched on handshake and applied on the next base strobe.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BASE_FREQ = 1000,
  parameter int unsigned NCH       = 4,
  parameter int unsigned PERIOD_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pause,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [clog2_min1(NCH)-1:0]    cfg_ch,
  input  logic                          cfg_en,
  input  logic [PERIOD_W-1:0]           cfg_period,
  output logic                          base_tick,
  output logic [NCH-1:0]                tick
);

  localparam int unsigned CH_W = clog2_min1(NCH);

  logic                strobe_c;
  logic                apply_c;

  cfg_state_e          state_q;
  logic                cfg_ready_q;
  logic [CH_W-1:0]     lat_ch_q;
  logic                lat_en_q;
  logic [PERIOD_W-1:0] lat_per_q;

  logic                en_q  [NCH];
  logic                en_d  [NCH];
  logic [PERIOD_W-1:0] per_q [NCH];
  logic [PERIOD_W-1:0] per_d [NCH];
  logic [PERIOD_W-1:0] cnt_q [NCH];
  logic [PERIOD_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]      tick_q, tick_d;
  logic                base_tick_q;

  tick_prescaler #(
    .CLK_FREQ  (CLK_FREQ),
    .BASE_FREQ (BASE_FREQ)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (pause),
    .strobe (strobe_c)
  );

  assign apply_c = (state_q == ST_WAIT) && strobe_c;

  // Channel next-state: a pending config on this strobe overrides the
  // channel's own count and swallows its tick.
  always_comb begin
    logic [PERIOD_W-1:0] last_cnt;
    last_cnt = '0;
    tick_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      en_d[i]  = en_q[i];
      per_d[i] = per_q[i];
      cnt_d[i] = cnt_q[i];
      last_cnt = (per_q[i] == '0) ? '0 : per_q[i] - PERIOD_W'(1);
      if (strobe_c) begin
        if (apply_c && (lat_ch_q == CH_W'(i))) begin
          en_d[i]  = lat_en_q;
          per_d[i] = lat_per_q;
          cnt_d[i] = '0;
        end else if (en_q[i]) begin
          if (cnt_q[i] == last_cnt) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Config FSM plus all channel and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_ready_q <= 1'b1;
      lat_ch_q    <= '0;
      lat_en_q    <= 1'b0;
      lat_per_q   <= '0;
      base_tick_q <= 1'b0;
      tick_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        en_q[i]  <= 1'b0;
        per_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      base_tick_q <= strobe_c;
      tick_q      <= tick_d;
      for (int i = 0; i < NCH; i++) begin
        en_q[i]  <= en_d[i];
        per_q[i] <= per_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid && cfg_ready_q) begin
            lat_ch_q    <= cfg_ch;
            lat_en_q    <= cfg_en;
            lat_per_q   <= cfg_period;
            state_q     <= ST_WAIT;
            cfg_ready_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (strobe_c) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign base_tick = base_tick_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler (DIV=10, NCH=3, PERIOD_W=4).
module tb_game_tick_scheduler;

  localparam int NCH = 3;
  localparam int DIV = 10;

  logic       clk;
  logic       rst_n;
  logic       pause;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic       cfg_en;
  logic [3:0] cfg_period;
  logic       base_tick;
  logic [2:0] tick;

  game_tick_scheduler #(
    .CLK_FREQ  (1000),
    .BASE_FREQ (100),
    .NCH       (NCH),
    .PERIOD_W  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pause      (pause),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_en     (cfg_en),
    .cfg_period (cfg_period),
    .base_tick  (base_tick),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: time measured in unpaused cycles and in strobes;
  // a channel fires when the strobes since its last event equal its period.
  int       act_n, strobe_n;
  bit       m_en   [NCH];
  int       m_per  [NCH];
  int       m_last [NCH];
  bit       pend;
  int       p_ch, p_per;
  bit       p_en;
  bit       m_ready, m_base;
  bit [2:0] m_tick;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit s;
    if (!rst_n) begin
      act_n = 0; strobe_n = 0; pend = 0; m_ready = 1; m_base = 0; m_tick = '0;
      for (int i = 0; i < NCH; i++) begin m_en[i] = 0; m_per[i] = 0; m_last[i] = 0; end
      return;
    end
    s = !pause && ((act_n % DIV) == DIV - 1);
    if (!pause) act_n++;
    m_tick = '0;
    if (s) begin
      strobe_n++;
      for (int i = 0; i < NCH; i++) begin
        if (pend && p_ch == i) begin
          m_en[i] = p_en; m_per[i] = p_per; m_last[i] = strobe_n;
        end else if (m_en[i] && (strobe_n - m_last[i]) == ((m_per[i] == 0) ? 1 : m_per[i])) begin
          m_tick[i] = 1'b1; m_last[i] = strobe_n;
        end
      end
    end
    if (pend) begin
      if (s) begin pend = 0; m_ready = 1; end
    end else if (cfg_valid) begin
      pend = 1; p_ch = int'(cfg_ch); p_en = cfg_en; p_per = int'(cfg_period); m_ready = 0;
    end
    m_base = s;
  endtask

  // One clock: advance model on current inputs, sample DUT 1 time unit after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("base_tick", 8'(base_tick), 8'(m_base));
    check("tick",      8'(tick),      8'(m_tick));
    check("cfg_ready", 8'(cfg_ready), 8'(m_ready));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (cfg_ready !== 1'b1 && k < budget) begin cycle(); k++; end
    if (cfg_ready !== 1'b1) check("wait_ready_timeout", 8'(cfg_ready), 8'd1);
  endtask

  task automatic cfg_write(input int ch, input bit en, input int per);
    wait_ready(30);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_en = en; cfg_period = 4'(per);
    cycle();
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    logic       rst_n;
    logic       pause;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic       cfg_en;
    logic [3:0] cfg_period;
    logic       exp_base;
    logic [2:0] exp_tick;
    logic       exp_ready;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t_base, gap, tick2_seen;
    rst_n = 1'b0; pause = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_period = '0;

    // Reset with random inputs, then three idle cycles after release.
    for (int i = 0; i < 6; i++) begin
      vecs[i].rst_n      = (i >= 3);
      vecs[i].pause      = (i < 3) ? 1'($urandom) : 1'b0;
      vecs[i].cfg_valid  = (i < 3) ? 1'($urandom) : 1'b0;
      vecs[i].cfg_ch     = 2'($urandom);
      vecs[i].cfg_en     = 1'($urandom);
      vecs[i].cfg_period = 4'($urandom);
      vecs[i].exp_base   = 1'b0;
      vecs[i].exp_tick   = 3'b000;
      vecs[i].exp_ready  = 1'b1;
    end
    for (int i = 0; i < 6; i++) begin
      rst_n = vecs[i].rst_n; pause = vecs[i].pause; cfg_valid = vecs[i].cfg_valid;
      cfg_ch = vecs[i].cfg_ch; cfg_en = vecs[i].cfg_en; cfg_period = vecs[i].cfg_period;
      if (i == 3) cyc = 0;
      cycle();
      check("vec_base",  8'(base_tick), 8'(vecs[i].exp_base));
      check("vec_tick",  8'(tick),      8'(vecs[i].exp_tick));
      check("vec_ready", 8'(cfg_ready), 8'(vecs[i].exp_ready));
    end

    // Restart cleanly so cycle numbering is relative to this release.
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; cyc = 0;
    run(2);
    cfg_write(0, 1'b1, 3);
    check("ready_drop_c3", 8'(cfg_ready), 8'd0);
    while (cyc < 71) begin
      cycle();
      if (cyc == 10) check("first_base_c10", 8'(base_tick), 8'd1);
      if (cyc == 20) check("base_c20", 8'(base_tick), 8'd1);
      if (cyc == 40 || cyc == 70) check("ch0_tick", 8'(tick[0]), 8'd1);
      if (cyc == 50 || cyc == 60) check("ch0_no_tick", 8'(tick[0]), 8'd0);
    end

    // Period 0 behaves as 1, then disable the channel.
    cfg_write(1, 1'b1, 0);
    run(35);
    cfg_write(1, 1'b0, 5);
    run(40);

    // Pause mid-count with a config issued during the pause.
    t_base = -1;
    for (int k = 0; k < 15 && t_base < 0; k++) begin
      cycle();
      if (base_tick === 1'b1) t_base = cyc;
    end
    if (t_base < 0) check("base_before_pause_timeout", 8'(base_tick), 8'd1);
    run(3);
    pause = 1'b1;
    cfg_write(2, 1'b1, 2);
    run(24);
    pause = 1'b0;
    gap = -1;
    for (int k = 0; k < 40 && gap < 0; k++) begin
      cycle();
      if (base_tick === 1'b1) gap = cyc - t_base;
    end
    check("pause_gap", 8'(gap), 8'd35);
    run(40);

    // Out-of-range channel: handshake only.
    cfg_write(3, 1'b1, 1);
    wait_ready(15);
    check("oob_ready", 8'(cfg_ready), 8'd1);
    run(30);

    // Reset while a write is pending discards it.
    cfg_write(1, 1'b1, 2);
    check("pend_ready_low", 8'(cfg_ready), 8'd0);
    rst_n = 1'b0;
    run(2);
    check("ready_after_rst", 8'(cfg_ready), 8'd1);
    rst_n = 1'b1;
    tick2_seen = 0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (tick !== 3'b000) tick2_seen++;
    end
    check("no_tick_after_rst", 8'(tick2_seen), 8'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst_n      = ($urandom_range(0, 499) != 0);
      pause      = ($urandom_range(0, 7) == 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom);
      cfg_en     = ($urandom_range(0, 3) != 0);
      cfg_period = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
